xnor_popcount_neuron: RTL

//  Binarized-neuron accumulate stage; sits directly upstream of the 1-bit vector register stage.

---
 rtl/bnn_pkg.sv | 14 +
 rtl/xnor_popcount_neuron_popcount_xnor.sv | 21 ++
 rtl/xnor_popcount_neuron.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the binarized-neuron datapath: default geometry,
// accumulator sizing helper and the accumulate/hold state type.
package bnn_pkg;

   localparam int unsigned N_DEF     = 16;
   localparam int unsigned BEATS_DEF = 4;

   function automatic int unsigned acc_width(input int unsigned n, input int unsigned beats);
      return $clog2(n * beats + 1);
   endfunction

   typedef enum logic {ACC, HOLD} neuron_state_t;

endpackage

// File: rtl/xnor_popcount_neuron_popcount_xnor.sv
// Combinational XNOR-popcount: number of positions where a and b agree.
module popcount_xnor #(
   parameter int unsigned N = 16
) (
   input  logic [N-1:0]             a,
   input  logic [N-1:0]             b,
   output logic [$clog2(N+1)-1:0]   cnt
);
   localparam int unsigned CW = $clog2(N + 1);

   logic [N-1:0] match;

   always_comb begin
      match = ~(a ^ b);
      cnt   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cnt = cnt + CW'(match[i]);
      end
   end

endmodule

// File: rtl/xnor_popcount_neuron.sv
// Binarized-neuron accumulate stage: sums XNOR popcounts over BEATS beats,
// thresholds the sum and offers bit + sum on a valid/ready output.
module xnor_popcount_neuron
   import bnn_pkg::*;
#(
   parameter  int unsigned N     = N_DEF,
   parameter  int unsigned BEATS = BEATS_DEF,
   parameter  int unsigned ACC_W = acc_width(N, BEATS),
   localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             act [N-1:0],
   input  logic             w   [N-1:0],
   input  logic [ACC_W-1:0] thr,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_bit,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] beat_cnt
);
   localparam int unsigned POP_W = $clog2(N + 1);

   neuron_state_t    state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [ACC_W-1:0] thr_q, thr_d;
   logic             out_valid_q, out_valid_d;
   logic             out_bit_q, out_bit_d;
   logic [ACC_W-1:0] out_sum_q, out_sum_d;

   logic [N-1:0]     act_p, w_p;
   logic [POP_W-1:0] pop;
   logic [ACC_W-1:0] acc_next;
   logic [ACC_W-1:0] thr_eff;
   logic             last_beat;

   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         act_p[i] = act[i];
         w_p[i]   = w[i];
      end
   end

   popcount_xnor #(.N(N)) u_popcount_xnor (
      .a   (act_p),
      .b   (w_p),
      .cnt (pop)
   );

   assign acc_next  = acc_q + ACC_W'(pop);
   assign last_beat = (BEATS == 1) || (beat_cnt_q == CNT_W'(BEATS - 1));
   // On the first beat the threshold register is still stale, so compare against the live input.
   assign thr_eff   = ((BEATS == 1) || (beat_cnt_q == '0)) ? thr : thr_q;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      beat_cnt_d  = beat_cnt_q;
      thr_d       = thr_q;
      out_valid_d = out_valid_q;
      out_bit_d   = out_bit_q;
      out_sum_d   = out_sum_q;
      in_ready    = 1'b0;

      unique case (state_q)
         ACC: begin
            in_ready = !flush;
            if (flush) begin
               acc_d      = '0;
               beat_cnt_d = '0;
            end else if (in_valid) begin
               if (beat_cnt_q == '0) begin
                  thr_d = thr;
               end
               if (last_beat) begin
                  out_sum_d   = acc_next;
                  out_bit_d   = (acc_next >= thr_eff);
                  out_valid_d = 1'b1;
                  acc_d       = '0;
                  beat_cnt_d  = '0;
                  state_d     = HOLD;
               end else begin
                  acc_d      = acc_next;
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ACC;
            end
         end
         default: state_d = ACC;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ACC;
         acc_q       <= '0;
         beat_cnt_q  <= '0;
         thr_q       <= '0;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
         out_sum_q   <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         beat_cnt_q  <= beat_cnt_d;
         thr_q       <= thr_d;
         out_valid_q <= out_valid_d;
         out_bit_q   <= out_bit_d;
         out_sum_q   <= out_sum_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_bit   = out_bit_q;
   assign out_sum   = out_sum_q;
   assign beat_cnt  = beat_cnt_q;

endmodule
